// File: rtl/credit_bcd_tracker.sv
// -----------------------------------------------------------------------------
// credit_bcd_tracker
//
// Purpose:
//   Credit accumulator for a small vending controller. Rising edges of the
//   debounced coin_5 / coin_10 / select / cancel levels are the only events.
//   Credit is kept in binary and is also shown as two registered BCD digits
//   for a seven-segment driver. A purchase pulses vend for one cycle; any
//   leftover credit (or a cancel) is offered back through a change handshake.
//
// Parameters:
//   PRICE       item price in credit units (1..99)
//   MAX_CREDIT  credit ceiling (PRICE..99); coins that would exceed it bounce
//
// Ports:
//   clk          system clock, rising edge active
//   rst_n        asynchronous active-low reset
//   coin_5       coin level worth 5 units
//   coin_10      coin level worth 10 units
//   select       purchase request level
//   cancel       refund request level
//   change_ack   dispenser has taken change_amt
//   tens, ones   registered BCD credit digits
//   vend         one-cycle dispense pulse
//   reject       one-cycle coin-return pulse
//   change_valid change offer valid (held until change_ack)
//   change_amt   binary change amount
//   busy         high while vending or refunding
//
// Configuration:
//   CREDIT_BLANK_IDLE_EN  when defined, both digits read 4'hF while idle
//                         (the display driver shows blank), including reset.
// -----------------------------------------------------------------------------
module credit_bcd_tracker #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       select,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       vend,
  output logic       reject,
  output logic       change_valid,
  output logic [6:0] change_amt,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_REFUND = 2'd3
  } state_e;

  localparam logic [6:0] PRICE_C = 7'(PRICE);
  localparam logic [7:0] MAX_C   = 8'(MAX_CREDIT);

`ifdef CREDIT_BLANK_IDLE_EN
  localparam logic [3:0] IDLE_DIGIT = 4'hF;
`else
  localparam logic [3:0] IDLE_DIGIT = 4'h0;
`endif

  // Bit positions inside the edge-history / event vectors.
  localparam int EV_C5     = 0;
  localparam int EV_C10    = 1;
  localparam int EV_SELECT = 2;
  localparam int EV_CANCEL = 3;

  // Binary credit to packed BCD {tens, ones}; credit never exceeds 99.
  function automatic logic [7:0] to_bcd(input logic [6:0] bin);
    logic [7:0] b8;
    b8 = {1'b0, bin};
    return ((b8 / 8'd10) << 3'd4) | (b8 % 8'd10);
  endfunction

  state_e     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic [3:0] hist_q, hist_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       vend_q, vend_d;
  logic       reject_q, reject_d;
  logic       change_valid_q, change_valid_d;
  logic [6:0] change_amt_q, change_amt_d;
  logic       busy_q, busy_d;

  logic [3:0] ev_s;
  logic [6:0] acc_s;

  // Next-state, credit arithmetic and registered-output computation.
  always_comb begin
    hist_d   = {cancel, select, coin_10, coin_5};
    ev_s     = hist_d & ~hist_q;
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    acc_s    = credit_q;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // cancel beats select beats coins; a coin arriving in the same cycle
        // as an accepted cancel/select is bounced because the machine is
        // leaving the coin-accepting states.
        if (ev_s[EV_CANCEL] && (state_q == ST_CREDIT)) begin
          state_d  = ST_REFUND;
          reject_d = ev_s[EV_C10] | ev_s[EV_C5];
        end else if (ev_s[EV_SELECT] && (state_q == ST_CREDIT) && (credit_q >= PRICE_C)) begin
          state_d  = ST_VEND;
          credit_d = credit_q - PRICE_C;
          reject_d = ev_s[EV_C10] | ev_s[EV_C5];
        end else begin
          // coin_10 is evaluated first; a simultaneous coin_5 always bounces.
          if (ev_s[EV_C10]) begin
            if (({1'b0, acc_s} + 8'd10) <= MAX_C) begin
              acc_s = acc_s + 7'd10;
            end else begin
              reject_d = 1'b1;
            end
          end else begin
            acc_s = credit_q;
          end
          if (ev_s[EV_C5]) begin
            if (ev_s[EV_C10]) begin
              reject_d = 1'b1;
            end else if (({1'b0, acc_s} + 8'd5) <= MAX_C) begin
              acc_s = acc_s + 7'd5;
            end else begin
              reject_d = 1'b1;
            end
          end else begin
            acc_s = acc_s;
          end
          credit_d = acc_s;
          if (acc_s != 7'd0) begin
            state_d = ST_CREDIT;
          end else begin
            state_d = state_q;
          end
        end
      end
      ST_VEND: begin
        reject_d = ev_s[EV_C10] | ev_s[EV_C5];
        if (credit_q != 7'd0) begin
          state_d = ST_REFUND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REFUND: begin
        reject_d = ev_s[EV_C10] | ev_s[EV_C5];
        if (change_ack) begin
          credit_d = 7'd0;
          state_d  = ST_IDLE;
        end else begin
          credit_d = credit_q;
          state_d  = ST_REFUND;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = 7'd0;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state register itself.
    vend_d         = (state_d == ST_VEND);
    busy_d         = (state_d == ST_VEND) || (state_d == ST_REFUND);
    change_valid_d = (state_d == ST_REFUND);
    if (change_valid_d) begin
      change_amt_d = credit_d;
    end else begin
      change_amt_d = 7'd0;
    end

    // Digits follow the current credit register, so the display trails a
    // credit update by exactly one cycle.
    if (state_q == ST_IDLE) begin
      tens_d = IDLE_DIGIT;
      ones_d = IDLE_DIGIT;
    end else begin
      {tens_d, ones_d} = to_bcd(credit_q);
    end
  end

  // State, credit, edge history and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      credit_q       <= 7'd0;
      hist_q         <= 4'b1111;  // levels held through reset give no event
      tens_q         <= IDLE_DIGIT;
      ones_q         <= IDLE_DIGIT;
      vend_q         <= 1'b0;
      reject_q       <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= 7'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      hist_q         <= hist_d;
      tens_q         <= tens_d;
      ones_q         <= ones_d;
      vend_q         <= vend_d;
      reject_q       <= reject_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      busy_q         <= busy_d;
    end
  end

  assign tens         = tens_q;
  assign ones         = ones_q;
  assign vend         = vend_q;
  assign reject       = reject_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign busy         = busy_q;

endmodule
